// File: rtl/minibyte_pkg.sv
// minibyte_pkg: shared types and constants for the minibyte memory interface.
//   BUS_W          - width of the external multiplexed address/data bus
//   RD_TIMEOUT_VAL - read data returned when an access times out
//   state_t        - memory sequencer FSM state encoding
package minibyte_pkg;

    localparam int BUS_W = 8;

    localparam logic [BUS_W-1:0] RD_TIMEOUT_VAL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/minibyte_genreg.sv
// minibyte_genreg: general-purpose load-enable register cell.
//   clk_in - clock, rising edge
//   rst_in - asynchronous active-low reset, clears q_out
//   set_in - load d_in on the next rising edge
//   d_in   - data to load
//   q_out  - held register value
module minibyte_genreg #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         set_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            q_out <= '0;
        else if (set_in)
            q_out <= d_in;
    end

endmodule

// File: rtl/minibyte_memif.sv
// minibyte_memif: memory bus sequencer for the minibyte CPU.
// Accepts one read/write request in IDLE and runs it on an 8-bit multiplexed
// address/data bus as ADDR (address + ALE) -> ACCESS (strobe, wait for ready)
// -> DONE (done pulse, bus turnaround) -> IDLE.
// Ports:
//   clk_in, rst_in          - clock, async active-low reset
//   req_in, we_in           - request strobe and direction (1 = write)
//   addr_in, wdata_in       - access address and write data, latched at accept
//   rdata_out               - last read data (held)
//   done_out, busy_out      - completion pulse, not-idle flag
//   err_out                 - last access timed out (held until next accept)
//   bus_out, bus_in         - multiplexed bus out/in
//   bus_oe_out              - bus pin output enable
//   ale_out, rd_out, wr_out - address latch enable, read and write strobes
//   mem_rdy_in              - memory ready, sampled in ACCESS
module minibyte_memif
    import minibyte_pkg::*;
#(
    parameter int               WAIT_MAX = 15,
    parameter logic [BUS_W-1:0] IDLE_BUS = 8'h00
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_in,
    input  logic             we_in,
    input  logic [BUS_W-1:0] addr_in,
    input  logic [BUS_W-1:0] wdata_in,
    output logic [BUS_W-1:0] rdata_out,
    output logic             done_out,
    output logic             busy_out,
    output logic             err_out,
    output logic [BUS_W-1:0] bus_out,
    input  logic [BUS_W-1:0] bus_in,
    output logic             bus_oe_out,
    output logic             ale_out,
    output logic             rd_out,
    output logic             wr_out,
    input  logic             mem_rdy_in
);

    localparam int            CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    wait_cnt;
    logic             we_q;
    logic             err_q;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] wdata_q;
    logic [BUS_W-1:0] rdata_d;

    logic accept;
    logic in_access;
    logic at_last;
    logic timeout;
    logic acc_end;
    logic rd_load;

    assign accept    = (state == ST_IDLE) && req_in;
    assign in_access = (state == ST_ACCESS);
    assign at_last   = (wait_cnt == CNT_LAST);
    assign timeout   = in_access && !mem_rdy_in && at_last;
    assign acc_end   = in_access && (mem_rdy_in || at_last);
    // Reads load the data latch both on capture and on timeout.
    assign rd_load   = acc_end && !we_q;
    assign rdata_d   = mem_rdy_in ? bus_in : RD_TIMEOUT_VAL;

    minibyte_genreg #(.W(BUS_W)) u_addr_reg (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .set_in (accept),
        .d_in   (addr_in),
        .q_out  (addr_q)
    );

    minibyte_genreg #(.W(BUS_W)) u_wdata_reg (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .set_in (accept),
        .d_in   (wdata_in),
        .q_out  (wdata_q)
    );

    minibyte_genreg #(.W(BUS_W)) u_rdata_reg (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .set_in (rd_load),
        .d_in   (rdata_d),
        .q_out  (rdata_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_in) state_nxt = ST_ADDR;
            ST_ADDR:   state_nxt = ST_ACCESS;
            ST_ACCESS: if (mem_rdy_in || at_last) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                we_q <= we_in;
            // Counter is cleared on the way into ACCESS and counts
            // not-ready cycles while there.
            if (state == ST_ADDR)
                wait_cnt <= '0;
            else if (in_access && !mem_rdy_in && !at_last)
                wait_cnt <= wait_cnt + CW'(1);
            if (accept)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign err_out  = err_q;
    assign busy_out = (state != ST_IDLE);
    assign done_out = (state == ST_DONE);

    // Moore decode: strobes and bus drive depend only on state and the
    // latched request, so an async reset drops them immediately.
    always_comb begin
        bus_out    = IDLE_BUS;
        bus_oe_out = 1'b0;
        ale_out    = 1'b0;
        rd_out     = 1'b0;
        wr_out     = 1'b0;
        case (state)
            ST_ADDR: begin
                bus_out    = addr_q;
                bus_oe_out = 1'b1;
                ale_out    = 1'b1;
            end
            ST_ACCESS: begin
                if (we_q) begin
                    bus_out    = wdata_q;
                    bus_oe_out = 1'b1;
                    wr_out     = 1'b1;
                end else begin
                    rd_out = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
